// File: rtl/nway_cache_pkg.sv
// Shared constants and helpers for the N-way set-associative write-back cache.
// FSM encodings, way-index width and line address construction.
package nway_cache_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CHECK      = 3'd1;
    localparam logic [2:0] ST_WRITEBACK  = 3'd2;
    localparam logic [2:0] ST_FILL       = 3'd3;
    localparam logic [2:0] ST_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] ST_FLUSH_WB   = 3'd5;
    localparam logic [2:0] ST_FLUSH_DONE = 3'd6;

    function automatic int way_bits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Line-aligned byte address from tag and set index.
    function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                              input int s_index, input int s_offset);
        return (tag << (s_index + s_offset)) | (index << s_offset);
    endfunction

endpackage

// File: rtl/nway_cache_if.sv
// CPU-side line port and memory-side line port of the cache.
// master drives the request; slave answers it.
interface nway_cpu_if #(parameter int S_OFFSET = 5);
    localparam int S_MASK = 2**S_OFFSET;
    localparam int S_LINE = 8*S_MASK;

    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [S_MASK-1:0] mem_byte_enable;
    logic [S_LINE-1:0] mem_wdata;
    logic [S_LINE-1:0] mem_rdata;
    logic              mem_resp;
    logic              flush_req;
    logic              flush_done;

    modport master (output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, flush_req,
                    input  mem_rdata, mem_resp, flush_done);
    modport slave  (input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata, flush_req,
                    output mem_rdata, mem_resp, flush_done);
endinterface

interface nway_mem_if #(parameter int S_OFFSET = 5);
    localparam int S_LINE = 8*(2**S_OFFSET);

    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic              pmem_write;
    logic [S_LINE-1:0] pmem_wdata;
    logic [S_LINE-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (output pmem_address, pmem_read, pmem_write, pmem_wdata,
                    input  pmem_rdata, pmem_resp);
    modport slave  (input  pmem_address, pmem_read, pmem_write, pmem_wdata,
                    output pmem_rdata, pmem_resp);
endinterface

// File: rtl/nway_cache_plru.sv
// Combinational tree pseudo-LRU: victim lookup and update for an accessed way.
// Heap layout: node n has children 2n+1 (left, bit=0) and 2n+2 (right, bit=1).
module plru_tree #(
    parameter int NUM_WAYS = 4,
    parameter int WAY_W    = (NUM_WAYS <= 2) ? 1 : $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-2:0] bits_cur,
    input  logic [WAY_W-1:0]    acc_way,
    output logic [NUM_WAYS-2:0] bits_nxt,
    output logic [WAY_W-1:0]    victim
);
    logic [WAY_W-1:0] vnode;
    logic [WAY_W-1:0] unode;

    always_comb begin
        victim = '0;
        vnode  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim[WAY_W-1-l] = bits_cur[vnode];
            vnode = WAY_W'(2*int'(vnode) + 1 + int'(bits_cur[vnode]));
        end
    end

    // Every node on the accessed path is turned to point at the other subtree.
    always_comb begin
        bits_nxt = bits_cur;
        unode    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            bits_nxt[unode] = ~acc_way[WAY_W-1-l];
            unode = WAY_W'(2*int'(unode) + 1 + int'(acc_way[WAY_W-1-l]));
        end
    end
endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU
// replacement, invalid-way-first allocation and a whole-cache flush engine.
module nway_cache
    import nway_cache_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 4,
    parameter int NUM_WAYS = 4,
    parameter int S_TAG    = 32 - S_OFFSET - S_INDEX,
    parameter int S_MASK   = 2**S_OFFSET,
    parameter int S_LINE   = 8*S_MASK
) (
    input logic        clk,
    input logic        rst,
    nway_cpu_if.slave  cpu,
    nway_mem_if.master pmem
);
    localparam int NUM_SETS = 2**S_INDEX;
    localparam int WAY_W    = way_bits(NUM_WAYS);

    generate
        if (NUM_WAYS != 2 && NUM_WAYS != 4 && NUM_WAYS != 8) begin : g_bad_ways
            $error("nway_cache: NUM_WAYS must be 2, 4 or 8");
        end
    endgenerate

    logic [S_TAG-1:0]    tag_arr   [NUM_SETS][NUM_WAYS];
    logic [S_LINE-1:0]   data_arr  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_arr [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_arr [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_arr  [NUM_SETS];

    logic [2:0]                 state;
    logic [WAY_W-1:0]           vic_way;
    logic [S_INDEX+WAY_W-1:0]   fl_cnt;
    logic [S_INDEX-1:0]         fl_set;
    logic [WAY_W-1:0]           fl_way;
    logic                       fl_last;

    logic [S_INDEX-1:0] idx;
    logic [S_TAG-1:0]   tag;
    logic               req;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic               inv_any;
    logic [WAY_W-1:0]   inv_way;
    logic [WAY_W-1:0]   plru_vic;
    logic [WAY_W-1:0]   miss_way;
    logic [NUM_WAYS-2:0] plru_nxt;
    logic               unused_addr;

    assign idx         = cpu.mem_address[S_OFFSET +: S_INDEX];
    assign tag         = cpu.mem_address[31 -: S_TAG];
    assign req         = cpu.mem_read | cpu.mem_write;
    assign unused_addr = ^cpu.mem_address[S_OFFSET-1:0];

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS-1; w >= 0; w--) begin
            if (valid_arr[idx][w] && tag_arr[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_arr[idx][w]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    plru_tree #(.NUM_WAYS(NUM_WAYS), .WAY_W(WAY_W)) u_plru (
        .bits_cur (plru_arr[idx]),
        .acc_way  (hit_way),
        .bits_nxt (plru_nxt),
        .victim   (plru_vic)
    );

    assign miss_way = inv_any ? inv_way : plru_vic;
    assign fl_set   = fl_cnt[WAY_W +: S_INDEX];
    assign fl_way   = fl_cnt[WAY_W-1:0];
    assign fl_last  = &fl_cnt;

    // Outputs decode from state only, so reset drops them asynchronously.
    assign cpu.mem_resp   = (state == ST_CHECK) && hit && req;
    assign cpu.mem_rdata  = cpu.mem_resp ? data_arr[idx][hit_way] : '0;
    assign cpu.flush_done = (state == ST_FLUSH_DONE);

    assign pmem.pmem_read  = (state == ST_FILL);
    assign pmem.pmem_write = (state == ST_WRITEBACK) || (state == ST_FLUSH_WB);
    assign pmem.pmem_address =
        (state == ST_WRITEBACK) ? line_addr(32'(tag_arr[idx][vic_way]), 32'(idx), S_INDEX, S_OFFSET) :
        (state == ST_FILL)      ? {cpu.mem_address[31:S_OFFSET], {S_OFFSET{1'b0}}} :
        (state == ST_FLUSH_WB)  ? line_addr(32'(tag_arr[fl_set][fl_way]), 32'(fl_set), S_INDEX, S_OFFSET) :
                                  32'd0;
    assign pmem.pmem_wdata =
        (state == ST_WRITEBACK) ? data_arr[idx][vic_way] :
        (state == ST_FLUSH_WB)  ? data_arr[fl_set][fl_way] : '0;

    // Tag/data are not reset; state is, so no write can land while rst is low.
    always_ff @(posedge clk) begin
        if (state == ST_FILL && pmem.pmem_resp) begin
            tag_arr[idx][vic_way]  <= tag;
            data_arr[idx][vic_way] <= pmem.pmem_rdata;
        end
        if (cpu.mem_resp && cpu.mem_write) begin
            for (int b = 0; b < S_MASK; b++) begin
                if (cpu.mem_byte_enable[b])
                    data_arr[idx][hit_way][8*b +: 8] <= cpu.mem_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            vic_way <= '0;
            fl_cnt  <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu.flush_req) begin
                        fl_cnt <= '0;
                        state  <= ST_FLUSH_SCAN;
                    end else if (req) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!req) begin
                        state <= ST_IDLE;
                    end else if (hit) begin
                        plru_arr[idx] <= plru_nxt;
                        if (cpu.mem_write) dirty_arr[idx][hit_way] <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        vic_way <= miss_way;
                        state   <= (valid_arr[idx][miss_way] && dirty_arr[idx][miss_way])
                                   ? ST_WRITEBACK : ST_FILL;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem.pmem_resp) state <= ST_FILL;
                end
                ST_FILL: begin
                    if (pmem.pmem_resp) begin
                        valid_arr[idx][vic_way] <= 1'b1;
                        dirty_arr[idx][vic_way] <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_FLUSH_SCAN: begin
                    if (valid_arr[fl_set][fl_way] && dirty_arr[fl_set][fl_way]) begin
                        state <= ST_FLUSH_WB;
                    end else if (fl_last) begin
                        state <= ST_FLUSH_DONE;
                    end else begin
                        fl_cnt <= fl_cnt + 1'b1;
                    end
                end
                ST_FLUSH_WB: begin
                    if (pmem.pmem_resp) begin
                        dirty_arr[fl_set][fl_way] <= 1'b0;
                        if (fl_last) begin
                            state <= ST_FLUSH_DONE;
                        end else begin
                            fl_cnt <= fl_cnt + 1'b1;
                            state  <= ST_FLUSH_SCAN;
                        end
                    end
                end
                ST_FLUSH_DONE: state <= ST_IDLE;
                default:       state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/nway_cache.md
Name: nway_cache

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Contains its own controller FSM, tree pseudo-LRU replacement and a whole-cache flush engine.
- Sits between a CPU-side line interface (full line plus byte mask) and the physical memory / arbiter line port.
- Successor to the fixed 2-way, 16-set datapath. Adds configurable ways and sets, PLRU for more than 2 ways, invalid-way-first allocation, and flush.

Parameters:
- S_OFFSET, 5: byte-offset bits; line = 2**S_OFFSET bytes.
- S_INDEX, 4: index bits; NUM_SETS = 2**S_INDEX.
- NUM_WAYS, 4: associativity; legal values 2, 4, 8. Elaboration error otherwise.
- S_TAG, 32-S_OFFSET-S_INDEX: tag width (derived).
- S_MASK, 2**S_OFFSET: byte-enable width (derived).
- S_LINE, 8*S_MASK: line width in bits (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset). Deassertion is synchronised externally.
- mem_address  in  32  CPU byte address; held stable until mem_resp.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp. Never asserted together with mem_read.
- mem_byte_enable  in  S_MASK  per-byte write mask within the line.
- mem_wdata  in  S_LINE  write line data.
- mem_rdata  out  S_LINE  read line data; valid while mem_resp=1.
- mem_resp  out  1  one-cycle completion pulse.
- flush_req  in  1  level request to write back every dirty line; held until flush_done.
- flush_done  out  1  one-cycle pulse when the flush completes.
- pmem_address  out  32  line-aligned memory address (low S_OFFSET bits = 0).
- pmem_read  out  1  memory line read; held until pmem_resp.
- pmem_write  out  1  memory line write; held until pmem_resp.
- pmem_wdata  out  S_LINE  victim line data.
- pmem_rdata  in  S_LINE  fill data; valid with pmem_resp.
- pmem_resp  in  1  memory completion pulse.

Behaviour:
- Storage: per set and way, hold tag, data, valid and dirty. Per set, hold NUM_WAYS-1 PLRU bits. Flop arrays with combinational read.
- Reset: all valid, dirty and PLRU bits = 0; FSM = IDLE; all outputs = 0. Tag and data are not reset.
- Reset asserted mid-transaction aborts immediately. pmem_read/pmem_write drop asynchronously; no partial line is written.
- States:
  - IDLE: flush_req has priority. flush_req → FLUSH_SCAN with set counter = 0 and way counter = 0. Else mem_read|mem_write → CHECK.
  - CHECK: compare tag across all valid ways.
    - Hit: mem_resp=1 this cycle and mem_rdata = hit way data. A write merges mem_wdata under mem_byte_enable and sets dirty. Update PLRU to point away from the hit way. Go to IDLE.
    - Hit latency: request first seen in IDLE at cycle t gives mem_resp at t+1.
    - Miss: victim = lowest-index invalid way if any, else the PLRU victim. Victim valid and dirty → WRITEBACK, else FILL. Victim latched in a register.
  - WRITEBACK: pmem_write=1, pmem_address = {victim tag, index, 0}, pmem_wdata = victim data. On pmem_resp → FILL.
  - FILL: pmem_read=1, pmem_address = {mem_address[31:S_OFFSET], 0}. On pmem_resp: write pmem_rdata and the tag into the victim way, valid=1, dirty=0 → CHECK. CHECK then hits.
  - FLUSH_SCAN: examine (set, way).
    - Valid and dirty → FLUSH_WB.
    - Otherwise advance way, then set.
    - After the last set and way → FLUSH_DONE.
  - FLUSH_WB: same as WRITEBACK for the scanned line. On pmem_resp clear dirty (valid stays 1), advance the counter, → FLUSH_SCAN.
  - FLUSH_DONE: flush_done=1 for one cycle → IDLE.
- PLRU: binary tree, node 0 = root.
  - Bit 0 points left, bit 1 points right; victim = follow the bits.
  - On access, set each node on the path to point away from the accessed way.
  - PLRU is updated only on CHECK hits, not on fills or flush.
- pmem_read and pmem_write are never both 1. Both are 0 in IDLE, CHECK, FLUSH_SCAN and FLUSH_DONE.
- pmem_resp arriving outside WRITEBACK, FILL or FLUSH_WB is ignored.
- A CPU request arriving during a flush waits until after FLUSH_DONE.
- Flush cost: NUM_SETS*NUM_WAYS scan cycles plus write-backs.

Decomposition:
- cache_pkg holds:
  - the state enum (IDLE, CHECK, WRITEBACK, FILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE);
  - functions for derived widths (clog2 of NUM_WAYS);
  - the line-address build helper.
- One sub-module, plru_tree, parameterised on NUM_WAYS. It is combinational: inputs are the current bits and the accessed way; outputs are the next bits and the victim way.
- nway_cache instantiates one plru_tree and owns all arrays and the FSM.

Test Plan:
- Fill check: after reset, read 0x0000_1000 → FILL with pmem_address 0x0000_1000. Return line 0xA5..A5 → mem_resp with rdata 0xA5..A5, no pmem_write. Re-read → hit, mem_resp exactly 1 cycle after request, no pmem activity.
- Byte-masked write: write 0x0000_1004 with mem_byte_enable=0x0000_00F0 and wdata bytes 4-7 = 0x11223344 over the previous line. Read back → bytes 4-7 = 0x11223344, other bytes 0xA5.
- Invalid-first then PLRU (NUM_WAYS=4): read tags T0..T3 into set 0 → four fills into ways 0..3, no write-back. Access order T0, T2, T1, T3, then read T4 → victim is the PLRU choice (way 0). Expect pmem_write only if way 0 is dirty.
- Dirty eviction: write T0 in set 0, then miss four new tags into set 0. Expect pmem_write with pmem_address = T0 line address and wdata = the written line, then pmem_read for the new tag.
- Flush: dirty lines in set 3 way 1 and set 15 way 2, assert flush_req. Expect exactly two pmem_write bursts in that order, then flush_done; a subsequent flush issues zero writes.
- Reset mid-FILL: drop rst while pmem_read=1 → pmem_read=0 immediately. After release, a read of the same address misses.
